// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - RV32I multicycle control FSM (IF-ID-EX-MEM-WB) with memory wait timeout
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        illegal,
  output logic        mem_timeout
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ} iclass_t;

  localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000,
                         ALU_OR  = 4'b0001, ALU_XOR = 4'b0011, ALU_SLT = 4'b0111,
                         ALU_SLL = 4'b1000, ALU_SRL = 4'b1001, ALU_SRA = 4'b1010;
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  // Only funct7, funct3 and opcode steer control; operand fields belong to the datapath.
  logic [16:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        dec_legal;
  logic [3:0]  dec_alu;
  iclass_t     dec_cls;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
  assign f7 = ir_q[16:10];
  assign f3 = ir_q[9:7];
  assign op = ir_q[6:0];

  always_comb begin
    dec_legal = 1'b0;
    dec_alu   = ALU_ADD;
    dec_cls   = C_R;
    case (op)
      7'b0110011: begin
        dec_cls = C_R;
        case (f3)
          3'b000: begin
            dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            dec_alu   = f7[5] ? ALU_SUB : ALU_ADD;
          end
          3'b001: begin dec_legal = (f7 == 7'b0000000); dec_alu = ALU_SLL; end
          3'b010: begin dec_legal = (f7 == 7'b0000000); dec_alu = ALU_SLT; end
          3'b100: begin dec_legal = (f7 == 7'b0000000); dec_alu = ALU_XOR; end
          3'b101: begin
            dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            dec_alu   = f7[5] ? ALU_SRA : ALU_SRL;
          end
          3'b110: begin dec_legal = (f7 == 7'b0000000); dec_alu = ALU_OR; end
          3'b111: begin dec_legal = (f7 == 7'b0000000); dec_alu = ALU_AND; end
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_cls = C_I;
        case (f3)
          3'b000: begin dec_legal = 1'b1; dec_alu = ALU_ADD; end
          3'b010: begin dec_legal = 1'b1; dec_alu = ALU_SLT; end
          3'b100: begin dec_legal = 1'b1; dec_alu = ALU_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_alu = ALU_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_alu = ALU_AND; end
          3'b001: begin dec_legal = (f7 == 7'b0000000); dec_alu = ALU_SLL; end
          3'b101: begin
            dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            dec_alu   = f7[5] ? ALU_SRA : ALU_SRL;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000011: begin dec_cls = C_LW;  dec_legal = (f3 == 3'b010); dec_alu = ALU_ADD; end
      7'b0100011: begin dec_cls = C_SW;  dec_legal = (f3 == 3'b010); dec_alu = ALU_ADD; end
      7'b1100011: begin dec_cls = C_BEQ; dec_legal = (f3 == 3'b000); dec_alu = ALU_SUB; end
      default:    dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IF;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    cnt_d       = '0;
    PCSrc       = 1'b0;
    ALUSrc      = 1'b0;
    RegWrite    = 1'b0;
    MemToReg    = 1'b0;
    ALUCtrl     = 4'b0000;
    loadPC      = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    case (state_q)
      S_IF: begin
        if (instr_valid) begin
          ir_d    = {instr[31:25], instr[14:12], instr[6:0]};
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (dec_legal) begin
          state_d = S_EX;
        end else begin
          illegal = 1'b1;
          state_d = S_IF;
        end
      end
      S_EX: begin
        ALUCtrl = dec_alu;
        ALUSrc  = (dec_cls == C_I) || (dec_cls == C_LW) || (dec_cls == C_SW);
        case (dec_cls)
          C_R, C_I:   state_d = S_WB;
          C_LW, C_SW: state_d = S_MEM;
          C_BEQ: begin
            loadPC  = 1'b1;
            PCSrc   = Zero;
            state_d = S_IF;
          end
          default:    state_d = S_IF;
        endcase
      end
      S_MEM: begin
        // Timeout wins over a late mem_ready: the access is abandoned and the PC moves on.
        if (cnt_q == TIMEOUT_CNT) begin
          mem_timeout = 1'b1;
          loadPC      = 1'b1;
          state_d     = S_IF;
        end else begin
          MemRead  = (dec_cls == C_LW);
          MemWrite = (dec_cls == C_SW);
          if (mem_ready) begin
            if (dec_cls == C_SW) begin
              loadPC  = 1'b1;
              state_d = S_IF;
            end else begin
              state_d = S_WB;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = (dec_cls == C_LW);
        loadPC   = 1'b1;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        Zero;
  logic        mem_ready;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal, mem_timeout;
  logic [3:0]  ALUCtrl;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];
  logic [12:0] got, exp_v;

  localparam logic [12:0] Z = 13'h0;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRAI = 32'h4040D193;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_SLTU = 32'h0020B1B3;
  localparam logic [31:0] JUNK   = 32'hFFFFFFFF;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .Zero(Zero),
    .mem_ready(mem_ready), .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .MemToReg(MemToReg), .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead),
    .MemWrite(MemWrite), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic pcs, input logic als, input logic rw,
                                     input logic m2r, input logic [3:0] alu, input logic ld,
                                     input logic mrd, input logic mwr, input logic ill,
                                     input logic tmo);
    return {pcs, als, rw, m2r, alu, ld, mrd, mwr, ill, tmo};
  endfunction

  task automatic cyc(input logic r, input logic iv, input logic [31:0] ins, input logic z,
                     input logic mr, input logic [12:0] e, input string tag);
    @(negedge clk);
    rst = r; instr_valid = iv; instr = ins; Zero = z; mem_ready = mr;
    exp_q.push_back(e);
    #1;
    got   = {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite,
             illegal, mem_timeout};
    exp_v = exp_q.pop_front();
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp_v);
    end
  endtask

  task automatic fetch_decode(input logic [31:0] ins, input string tag);
    cyc(1, 1, ins, 0, 1, Z, {tag, "_if"});
    cyc(1, 0, JUNK, 0, 1, Z, {tag, "_id"});
  endtask

  initial begin
    rst = 1'b0; instr = '0; instr_valid = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
    cyc(0, 1, I_ADD, 0, 1, Z, "reset0");
    cyc(0, 0, JUNK, 1, 1, Z, "reset1");
    cyc(1, 0, I_ADD, 0, 1, Z, "if_stall0");
    cyc(1, 0, I_ADD, 0, 1, Z, "if_stall1");

    fetch_decode(I_ADD, "add");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0010,0,0,0,0,0), "add_ex");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,1,0,4'b0000,1,0,0,0,0), "add_wb");

    fetch_decode(I_SUB, "sub");
    cyc(1, 0, JUNK, 1, 0, mk(0,0,0,0,4'b0110,0,0,0,0,0), "sub_ex");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,1,0,4'b0000,1,0,0,0,0), "sub_wb");

    fetch_decode(I_SRAI, "srai");
    cyc(1, 0, JUNK, 0, 0, mk(0,1,0,0,4'b1010,0,0,0,0,0), "srai_ex");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,1,0,4'b0000,1,0,0,0,0), "srai_wb");

    fetch_decode(I_BEQ, "beq_t");
    cyc(1, 0, JUNK, 1, 0, mk(1,0,0,0,4'b0110,1,0,0,0,0), "beq_t_ex");
    fetch_decode(I_BEQ, "beq_n");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0110,1,0,0,0,0), "beq_n_ex");
    cyc(1, 0, JUNK, 0, 1, Z, "beq_n_back_if");

    fetch_decode(I_LW, "lw");
    cyc(1, 0, JUNK, 0, 1, mk(0,1,0,0,4'b0010,0,0,0,0,0), "lw_ex");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0000,0,1,0,0,0), "lw_mem_wait");
    cyc(1, 0, JUNK, 0, 1, mk(0,0,0,0,4'b0000,0,1,0,0,0), "lw_mem_ready");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,1,1,4'b0000,1,0,0,0,0), "lw_wb");

    fetch_decode(I_SW, "sw");
    cyc(1, 0, JUNK, 0, 0, mk(0,1,0,0,4'b0010,0,0,0,0,0), "sw_ex");
    cyc(1, 0, JUNK, 0, 1, mk(0,0,0,0,4'b0000,1,0,1,0,0), "sw_mem_ready");

    fetch_decode(I_SW, "swto");
    cyc(1, 0, JUNK, 0, 0, mk(0,1,0,0,4'b0010,0,0,0,0,0), "swto_ex");
    for (int i = 0; i < 15; i++)
      cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0000,0,0,1,0,0), "swto_mem_wait");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0000,1,0,0,0,1), "swto_timeout");
    cyc(1, 0, JUNK, 0, 1, Z, "swto_back_if");

    cyc(1, 1, I_BAD, 0, 0, Z, "bad_if");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0000,0,0,0,1,0), "bad_id");
    cyc(1, 0, JUNK, 0, 0, Z, "bad_back_if");
    cyc(1, 1, I_SLTU, 0, 0, Z, "sltu_if");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0000,0,0,0,1,0), "sltu_id");

    fetch_decode(I_LW, "lwrst");
    cyc(1, 0, JUNK, 0, 0, mk(0,1,0,0,4'b0010,0,0,0,0,0), "lwrst_ex");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0000,0,1,0,0,0), "lwrst_mem");
    cyc(0, 0, JUNK, 0, 1, mk(0,0,0,0,4'b0000,0,1,0,0,0), "lwrst_rst_edge");
    cyc(1, 0, JUNK, 0, 1, Z, "lwrst_after");
    fetch_decode(I_ADD, "add2");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,0,0,4'b0010,0,0,0,0,0), "add2_ex");
    cyc(1, 0, JUNK, 0, 0, mk(0,0,1,0,4'b0000,1,0,0,0,0), "add2_wb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
